// File: rtl/maf_issue_ctrl.sv
// Issue/collect controller for the two-stage multiply-add datapath.
// Operations are accepted over valid/ready and steered into the datapath.
// The block follows each operation through the fixed datapath latency and
// captures the result, tag and func into an in-order output FIFO. The
// datapath cannot stall. Issue is throttled by credits so that every result
// has a FIFO slot reserved before it leaves the datapath.
module maf_issue_ctrl #(
  parameter int BITS  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_func,
  input  logic [BITS-1:0]            in_a,
  input  logic [BITS-1:0]            in_b,
  input  logic [BITS-1:0]            in_c,
  input  logic [TAG_W-1:0]           in_tag,

  output logic [1:0]                 dp_func,
  output logic [BITS-1:0]            dp_a,
  output logic [BITS-1:0]            dp_b,
  output logic [BITS-1:0]            dp_c,
  input  logic [2*BITS-1:0]          dp_result,

  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*BITS-1:0]          out_result,
  output logic [TAG_W-1:0]           out_tag,
  output logic [1:0]                 out_func,

  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic [15:0]                done_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Stage-1 tracking of the operation currently inside the datapath.
  logic              s1_v;
  logic [TAG_W-1:0]  s1_tag;
  logic [1:0]        s1_func;

  // Output FIFO storage and pointers.
  logic [2*BITS-1:0] res_mem  [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [1:0]        func_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic              fire;
  logic              push;
  logic              pop;
  logic [CW-1:0]     committed;

  // Credits count entries already in the FIFO plus the one still in flight.
  // Only registered state is used, so out_ready and in_valid never reach
  // in_ready combinationally; a pop frees its credit one cycle later.
  assign committed = count + CW'(s1_v);
  assign in_ready  = committed < CW'(DEPTH);

  assign fire = in_valid & in_ready;
  assign push = s1_v;
  assign pop  = out_valid & out_ready;

  // Operands go to the datapath only on a firing cycle; idle cycles carry
  // zeros so the datapath sees quiet inputs when nothing is issued.
  always_comb begin
    dp_func = 2'b00;
    dp_a    = '0;
    dp_b    = '0;
    dp_c    = '0;
    if (fire) begin
      dp_func = in_func;
      dp_a    = in_a;
      dp_b    = in_b;
      dp_c    = in_c;
    end
  end

  // Track the issued operation for one edge, matching the datapath register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_tag  <= '0;
      s1_func <= 2'b00;
    end else begin
      s1_v <= fire;
      if (fire) begin
        s1_tag  <= in_tag;
        s1_func <= in_func;
      end
    end
  end

  // FIFO storage write; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wr_ptr]  <= dp_result;
      tag_mem[wr_ptr]  <= s1_tag;
      func_mem[wr_ptr] <= s1_func;
    end
  end

  // FIFO pointers and occupancy; the credit scheme keeps push off a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Completed-pop counter, free-running and wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= 16'd0;
    end else if (pop) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end

  assign out_valid  = count != '0;
  assign out_result = res_mem[rd_ptr];
  assign out_tag    = tag_mem[rd_ptr];
  assign out_func   = func_mem[rd_ptr];
  assign busy       = s1_v | (count != '0);

endmodule

// File: tb/tb_maf_issue_ctrl.sv
// Directed bench for maf_issue_ctrl with a behavioural two-stage DATAP model.
module tb_maf_issue_ctrl;

  localparam int BITS  = 8;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_func;
  logic [BITS-1:0]   in_a, in_b, in_c;
  logic [TAG_W-1:0]  in_tag;
  logic [1:0]        dp_func;
  logic [BITS-1:0]   dp_a, dp_b, dp_c;
  logic [2*BITS-1:0] dp_result;
  logic              out_valid;
  logic              out_ready;
  logic [2*BITS-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;
  logic [1:0]        out_func;
  logic [2:0]        count;
  logic              busy;
  logic [15:0]       done_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  maf_issue_ctrl #(.BITS(BITS), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_tag(in_tag),
    .dp_func(dp_func), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
    .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_func(out_func),
    .count(count), .busy(busy), .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DATAP: input register every edge, arithmetic in the second stage.
  logic [BITS-1:0]   ra, rb, rc;
  logic [1:0]        rf;
  logic [2*BITS-1:0] prod, addend;
  always @(posedge clk) begin
    ra <= dp_a; rb <= dp_b; rc <= dp_c; rf <= dp_func;
  end
  always_comb begin
    prod   = '0;
    addend = '0;
    if (rf[0]) prod = {{BITS{1'b0}}, ra};
    else       prod = (2*BITS)'(ra) * (2*BITS)'(rb);
    if (rf != 2'b00) addend = {{BITS{rc[BITS-1]}}, rc};
    dp_result = prod + addend;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    in_valid = 1'b0; in_func = 2'b00; in_a = '0; in_b = '0; in_c = '0; in_tag = '0;
  endtask

  // Offer one op starting after the next edge; returns 1ns after its fire edge.
  task automatic issue(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [3:0] t);
    logic r;
    bit   fired;
    fired = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_func = f; in_a = a; in_b = b; in_c = c; in_tag = t;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk);
      if (r) begin fired = 1; break; end
    end
    #1 clear_in();
    if (!fired) check("issue_timeout", 32'd0, 32'd1);
  endtask

  // Wait (bounded) for out_valid at a negedge.
  task automatic wait_out(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic       r;
    int         fires;
    logic [9:0] exp_rdy;

    clear_in();
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_done_cnt",  32'(done_cnt),  32'd0);
    check("idle_dp_a",     32'(dp_a),      32'd0);

    // Basic multiply-add with exact 2-cycle latency: 3*5+7 = 0x16
    @(posedge clk); #1;
    in_valid = 1'b1; in_func = 2'b10; in_a = 8'd3; in_b = 8'd5; in_c = 8'd7; in_tag = 4'd2;
    @(negedge clk);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    check("t1_dp_a",     32'(dp_a),     32'd3);
    check("t1_dp_b",     32'(dp_b),     32'd5);
    check("t1_dp_c",     32'(dp_c),     32'd7);
    check("t1_dp_func",  32'(dp_func),  32'd2);
    @(posedge clk); #1 clear_in();
    @(negedge clk);
    check("t1_lat1_valid", 32'(out_valid), 32'd0);
    check("t1_lat1_busy",  32'(busy),      32'd1);
    check("t1_dp_a_idle",  32'(dp_a),      32'd0);
    @(negedge clk);
    check("t1_valid",  32'(out_valid),  32'd1);
    check("t1_result", 32'(out_result), 32'h0016);
    check("t1_tag",    32'(out_tag),    32'd2);
    check("t1_func",   32'(out_func),   32'd2);
    check("t1_count",  32'(count),      32'd1);
    @(negedge clk);
    check("t1_done_cnt", 32'(done_cnt),  32'd1);
    check("t1_drained",  32'(out_valid), 32'd0);
    check("t1_idle",     32'(busy),      32'd0);

    // Sign extension and wrap
    issue(2'b01, 8'd10, 8'd0, 8'hFF, 4'd5);
    wait_out("t2a");
    check("t2a_result", 32'(out_result), 32'h0009);
    check("t2a_tag",    32'(out_tag),    32'd5);
    issue(2'b00, 8'hFF, 8'hFF, 8'h55, 4'd6);
    wait_out("t2b");
    check("t2b_result", 32'(out_result), 32'hFE01);
    check("t2b_func",   32'(out_func),   32'd0);

    // Back-to-back issue, tags 1..4, results tag*2
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_func = 2'b00; in_a = 8'(i + 1); in_b = 8'd2; in_c = 8'd0;
        in_tag = 4'(i + 1);
      end else begin
        clear_in();
      end
      @(negedge clk);
      if (i < 4) check($sformatf("t3_in_ready%0d", i), 32'(in_ready), 32'd1);
      if (i >= 2) begin
        check($sformatf("t3_valid%0d", i),  32'(out_valid),  32'd1);
        check($sformatf("t3_tag%0d", i),    32'(out_tag),    32'(i - 1));
        check($sformatf("t3_result%0d", i), 32'(out_result), 32'(2 * (i - 1)));
      end else begin
        check($sformatf("t3_early%0d", i), 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t3_after", 32'(out_valid), 32'd0);
    check("t3_done_cnt", 32'(done_cnt), 32'd7);

    // Backpressure: out_ready low, in_valid held, only 4 credits
    @(posedge clk); #1;
    out_ready = 1'b0;
    fires = 0;
    exp_rdy = 10'b00_0000_1111;
    in_valid = 1'b1; in_func = 2'b01; in_a = 8'd0; in_b = 8'd0; in_c = 8'd0; in_tag = 4'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); r = in_ready;
      check($sformatf("t4_ready%0d", i), 32'(r), 32'(exp_rdy[i]));
      @(posedge clk);
      if (r) fires++;
      #1 in_tag = 4'(fires);
    end
    check("t4_fires",    32'(fires),     32'd4);
    check("t4_count",    32'(count),     32'd4);
    check("t4_valid",    32'(out_valid), 32'd1);
    check("t4_head_tag", 32'(out_tag),   32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_pop_tag",   32'(out_tag),  32'd0);
    check("t4_pop_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("t4_ready_back", 32'(in_ready), 32'd1);
    check("t4_count3",     32'(count),    32'd3);
    check("t4_head1",      32'(out_tag),  32'd1);
    @(posedge clk); #1 clear_in();
    @(negedge clk);
    check("t4_ready_full", 32'(in_ready), 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("t4_drain_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("t4_drain_tag%0d", k),   32'(out_tag),   32'(k));
      check($sformatf("t4_drain_res%0d", k),   32'(out_result), 32'd0);
      @(posedge clk);
    end
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("t4_empty", 32'(count), 32'd0);
    check("t4_done_cnt", 32'(done_cnt), 32'd12);

    // Simultaneous push and pop at count=2
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; in_func = 2'b00; in_a = 8'(j + 1); in_b = 8'd3; in_c = 8'd0;
      in_tag = 4'(5 + j);
      @(negedge clk);
      check($sformatf("t5_ready%0d", j), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    clear_in();
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_count_pre", 32'(count),   32'd2);
    check("t5_head_pre",  32'(out_tag), 32'd5);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("t5_count_post", 32'(count),      32'd2);
    check("t5_head_post",  32'(out_tag),    32'd6);
    check("t5_res_post",   32'(out_result), 32'd6);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_last_tag", 32'(out_tag),    32'd7);
    check("t5_last_res", 32'(out_result), 32'd9);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("t5_done_cnt", 32'(done_cnt), 32'd15);
    check("t5_empty",    32'(count),    32'd0);

    // Reset with count=3 and one op in flight
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_func = 2'b10; in_a = 8'd9; in_b = 8'd9; in_c = 8'd1;
      in_tag = 4'(8 + j);
      @(negedge clk);
      check($sformatf("t6_ready%0d", j), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    clear_in();
    check("t6_count3", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_count", 32'(count),     32'd0);
    check("t6_rst_busy",  32'(busy),      32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t6_no_stale%0d", k), 32'(out_valid), 32'd0);
    end
    issue(2'b00, 8'd2, 8'd2, 8'd0, 4'd3);
    wait_out("t6_new");
    check("t6_new_result", 32'(out_result), 32'h0004);
    check("t6_new_tag",    32'(out_tag),    32'd3);
    @(negedge clk);
    check("t6_done_cnt", 32'(done_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
